// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 32-bit memory between the CPU
// instruction-fetch port and its data port. Each access runs
// IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE. In a conflict data wins, but fetch
// is forced through after STARVE_LIMIT consecutive losses.
// Optional macro MEM_PORT_ARBITER_STATS_EN adds grant/conflict counters.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [15:0] i_if_addr,
  output logic        o_if_ready,
  output logic [31:0] o_if_data,
  input  logic        i_d_req,
  input  logic        i_d_rw,
  input  logic [15:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_ready,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_valid,
  output logic        o_mem_rw,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
`ifdef MEM_PORT_ARBITER_STATS_EN
  output logic [15:0] o_stat_grants,
  output logic [15:0] o_stat_conflicts,
`endif
  output logic        o_stall
);

  localparam int WAIT_W   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_reg;
  logic                grant_d_reg;     // 1: current access belongs to the data port
  logic [STARVE_W-1:0] starve_cnt_reg;  // consecutive fetch losses in conflicts
  logic [WAIT_W-1:0]   wait_cnt_reg;    // remaining read-latency cycles
  logic                both_req;
  logic                pick_data;

  // Arbitration decision for the current IDLE cycle
  always_comb begin
    both_req  = i_if_req & i_d_req;
    pick_data = i_d_req & (~i_if_req | (starve_cnt_reg < STARVE_W'(STARVE_LIMIT)));
  end

  // Pipeline freezes while any request is still waiting for its ready pulse
  assign o_stall = (i_if_req & ~o_if_ready) | (i_d_req & ~o_d_ready);

  // Access sequencer with registered memory command and response outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      grant_d_reg    <= 1'b0;
      starve_cnt_reg <= '0;
      wait_cnt_reg   <= '0;
      o_mem_valid    <= 1'b0;
      o_mem_rw       <= 1'b0;
      o_mem_addr     <= '0;
      o_mem_wdata    <= '0;
      o_if_ready     <= 1'b0;
      o_if_data      <= '0;
      o_d_ready      <= 1'b0;
      o_d_rdata      <= '0;
    end else begin
      // Command fields and ready strobes are single-cycle; data outputs hold
      o_mem_valid <= 1'b0;
      o_mem_rw    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_ready  <= 1'b0;
      o_d_ready   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_if_req | i_d_req) begin
            state_reg   <= ISSUE;
            grant_d_reg <= pick_data;
            o_mem_valid <= 1'b1;
            if (pick_data) begin
              o_mem_rw    <= i_d_rw;
              o_mem_addr  <= i_d_addr;
              o_mem_wdata <= i_d_wdata;
            end else begin
              // A fetch is always a read with no write data
              o_mem_addr  <= i_if_addr;
            end
            if (!pick_data) begin
              starve_cnt_reg <= '0;
            end else if (both_req && (starve_cnt_reg < STARVE_W'(STARVE_LIMIT))) begin
              starve_cnt_reg <= starve_cnt_reg + STARVE_W'(1);
            end
          end
        end
        ISSUE: begin
          if (o_mem_rw) begin
            // Writes complete as soon as the strobe has been issued
            state_reg <= RESP;
            if (grant_d_reg) o_d_ready  <= 1'b1;
            else             o_if_ready <= 1'b1;
          end else begin
            state_reg    <= WAIT;
            wait_cnt_reg <= WAIT_W'(MEM_LATENCY);
          end
        end
        WAIT: begin
          if (wait_cnt_reg == WAIT_W'(1)) begin
            state_reg <= RESP;
            if (grant_d_reg) begin
              o_d_ready <= 1'b1;
              o_d_rdata <= i_mem_rdata;
            end else begin
              o_if_ready <= 1'b1;
              o_if_data  <= i_mem_rdata;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - WAIT_W'(1);
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] grants_reg;
  logic [15:0] conflicts_reg;

  // Free-running (wrapping) counts of grants and of IDLE-cycle conflicts
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      grants_reg    <= '0;
      conflicts_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (i_if_req | i_d_req) grants_reg    <= grants_reg + 16'd1;
      if (both_req)           conflicts_reg <= conflicts_reg + 16'd1;
    end
  end

  assign o_stat_grants    = grants_reg;
  assign o_stat_conflicts = conflicts_reg;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level timing model,
// behavioural memory, directed scenarios and a randomized request phase.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 3;
  localparam int MAXCYC       = 8192;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_if_req = 1'b0;
  logic [15:0] i_if_addr = '0;
  logic        o_if_ready;
  logic [31:0] o_if_data;
  logic        i_d_req = 1'b0;
  logic        i_d_rw = 1'b0;
  logic [15:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic        o_d_ready;
  logic [31:0] o_d_rdata;
  logic        o_mem_valid;
  logic        o_mem_rw;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = '0;
  logic        o_stall;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] o_stat_grants;
  logic [15:0] o_stat_conflicts;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(MEM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ready(o_if_ready), .o_if_data(o_if_data),
    .i_d_req(i_d_req), .i_d_rw(i_d_rw), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ready(o_d_ready), .o_d_rdata(o_d_rdata),
    .o_mem_valid(o_mem_valid), .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
`ifdef MEM_PORT_ARBITER_STATS_EN
    .o_stat_grants(o_stat_grants), .o_stat_conflicts(o_stat_conflicts),
`endif
    .o_stall(o_stall)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Environment memory (driven by the DUT strobes) and the model's own copy
  logic [31:0] env_mem [logic [15:0]];
  logic [31:0] mdl_mem [logic [15:0]];
  int          rq_cyc [$];
  logic [31:0] rq_val [$];

  function automatic logic [31:0] seed_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction
  function automatic logic [31:0] env_rd(input logic [15:0] a);
    return env_mem.exists(a) ? env_mem[a] : seed_word(a);
  endfunction
  function automatic logic [31:0] mdl_rd(input logic [15:0] a);
    return mdl_mem.exists(a) ? mdl_mem[a] : seed_word(a);
  endfunction

  // Transaction-level model state
  bit          m_busy = 1'b0;
  bit          m_d = 1'b0;
  bit          m_rw = 1'b0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;
  int          m_t0 = 0;
  int          m_rdy = 0;
  int          m_starve = 0;
  logic [31:0] m_if_data = '0;
  logic [31:0] m_d_rdata = '0;
  int          m_grants = 0;
  int          m_conf = 0;

  // Requester behaviour controls
  int raise_pct = 0;
  int cont_pct = 0;
  int force_rw = -1;
  bit prev_if_ready = 1'b0;
  bit prev_d_ready = 1'b0;

  // Sampled history, indexed by cycle
  logic        h_valid   [0:MAXCYC-1];
  logic        h_rw      [0:MAXCYC-1];
  logic [15:0] h_addr    [0:MAXCYC-1];
  logic [31:0] h_wdata   [0:MAXCYC-1];
  logic        h_if_rdy  [0:MAXCYC-1];
  logic        h_d_rdy   [0:MAXCYC-1];
  logic [31:0] h_if_data [0:MAXCYC-1];
  logic        h_stall   [0:MAXCYC-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic new_if_fields();
    i_if_addr = 16'($urandom_range(0, 31) * 4);
  endtask

  task automatic new_d_fields();
    i_d_rw    = (force_rw < 0) ? 1'($urandom_range(0, 1)) : 1'(force_rw);
    i_d_addr  = 16'($urandom_range(0, 31) * 4);
    i_d_wdata = $urandom;
  endtask

  // Per-cycle model evaluation and comparison of every DUT output
  task automatic model_cycle();
    bit grant_now;
    bit idle_now;
    bit both;
    bit d;
    bit e_valid, e_if_rdy, e_d_rdy, e_stall;
    grant_now = 1'b0;
    d = 1'b0;
    both = i_if_req && i_d_req;
    if (m_busy && cyc > m_rdy) m_busy = 1'b0;
    idle_now = !m_busy;
    if (idle_now && !i_reset && (i_if_req || i_d_req)) begin
      if (both) begin
        if (m_starve < STARVE_LIMIT) begin d = 1'b1; m_starve++; end
        else begin d = 1'b0; m_starve = 0; end
      end else if (i_d_req) begin
        d = 1'b1;
      end else begin
        d = 1'b0; m_starve = 0;
      end
      grant_now = 1'b1;
      m_busy = 1'b1;
      m_t0 = cyc;
      m_d = d;
      if (d) begin
        m_rw = i_d_rw; m_addr = i_d_addr; m_wdata = i_d_wdata;
      end else begin
        m_rw = 1'b0; m_addr = i_if_addr; m_wdata = '0;
      end
      if (m_rw) mdl_mem[m_addr] = m_wdata;
      else      m_rdata = mdl_rd(m_addr);
      m_rdy = cyc + (m_rw ? 2 : MEM_LATENCY + 2);
    end
    e_valid  = m_busy && (cyc == m_t0 + 1);
    e_if_rdy = m_busy && !m_d && (cyc == m_rdy);
    e_d_rdy  = m_busy && m_d && (cyc == m_rdy);
    if (e_if_rdy) m_if_data = m_rdata;
    if (e_d_rdy && !m_rw) m_d_rdata = m_rdata;
    e_stall = (i_if_req && !e_if_rdy) || (i_d_req && !e_d_rdy);
    chk("mem_valid", 32'(o_mem_valid), 32'(e_valid));
    chk("mem_rw", 32'(o_mem_rw), e_valid ? 32'(m_rw) : 32'd0);
    chk("mem_addr", 32'(o_mem_addr), e_valid ? 32'(m_addr) : 32'd0);
    chk("mem_wdata", o_mem_wdata, e_valid ? m_wdata : 32'd0);
    chk("if_ready", 32'(o_if_ready), 32'(e_if_rdy));
    chk("d_ready", 32'(o_d_ready), 32'(e_d_rdy));
    chk("if_data", o_if_data, m_if_data);
    if (!(e_d_rdy && m_rw)) chk("d_rdata", o_d_rdata, m_d_rdata);
    chk("stall", 32'(o_stall), 32'(e_stall));
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("stat_grants", 32'(o_stat_grants), 32'(m_grants % 65536));
    chk("stat_conflicts", 32'(o_stat_conflicts), 32'(m_conf % 65536));
`endif
    if (i_reset) begin
      m_busy = 1'b0; m_starve = 0; m_if_data = '0; m_d_rdata = '0;
      m_grants = 0; m_conf = 0;
    end else begin
      if (grant_now) m_grants++;
      if (idle_now && both) m_conf++;
    end
  endtask

  // One clock cycle: update requesters/memory, sample and check, advance
  task automatic step();
    if (i_if_req && prev_if_ready) begin
      if ($urandom_range(0, 99) < cont_pct) new_if_fields();
      else i_if_req = 1'b0;
    end else if (!i_if_req && $urandom_range(0, 99) < raise_pct) begin
      i_if_req = 1'b1; new_if_fields();
    end
    if (i_d_req && prev_d_ready) begin
      if ($urandom_range(0, 99) < cont_pct) new_d_fields();
      else i_d_req = 1'b0;
    end else if (!i_d_req && $urandom_range(0, 99) < raise_pct) begin
      i_d_req = 1'b1; new_d_fields();
    end
    while (rq_cyc.size() > 0 && rq_cyc[0] < cyc) begin
      void'(rq_cyc.pop_front()); void'(rq_val.pop_front());
    end
    if (rq_cyc.size() > 0 && rq_cyc[0] == cyc) begin
      void'(rq_cyc.pop_front());
      i_mem_rdata = rq_val.pop_front();
    end else begin
      i_mem_rdata = $urandom;
    end
    #1;
    model_cycle();
    prev_if_ready = o_if_ready;
    prev_d_ready  = o_d_ready;
    if (o_mem_valid) begin
      if (o_mem_rw) env_mem[o_mem_addr] = o_mem_wdata;
      else begin
        rq_cyc.push_back(cyc + MEM_LATENCY);
        rq_val.push_back(env_rd(o_mem_addr));
      end
    end
    if (cyc < MAXCYC) begin
      h_valid[cyc] = o_mem_valid; h_rw[cyc] = o_mem_rw; h_addr[cyc] = o_mem_addr;
      h_wdata[cyc] = o_mem_wdata; h_if_rdy[cyc] = o_if_ready; h_d_rdy[cyc] = o_d_ready;
      h_if_data[cyc] = o_if_data; h_stall[cyc] = o_stall;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_if_req = 1'b0; i_d_req = 1'b0;
    raise_pct = 0; cont_pct = 0; force_rw = -1;
    step();
    i_reset = 1'b0;
    prev_if_ready = 1'b0; prev_d_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int pulses;
    int guard;
    logic [7:0] order;
    @(posedge clk);
    #1;
    cyc = 1;
    do_reset();

    // Fetch only, 0x0010 -> 0xDEADBEEF
    env_mem[16'h0010] = 32'hDEADBEEF;
    mdl_mem[16'h0010] = 32'hDEADBEEF;
    s = cyc;
    i_if_req = 1'b1; i_if_addr = 16'h0010;
    repeat (6) step();
    chk("t1_valid", 32'(h_valid[s+1]), 32'd1);
    chk("t1_rw", 32'(h_rw[s+1]), 32'd0);
    chk("t1_addr", 32'(h_addr[s+1]), 32'h0010);
    chk("t1_ready", 32'(h_if_rdy[s+4]), 32'd1);
    chk("t1_data", h_if_data[s+4], 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) chk("t1_stall_busy", 32'(h_stall[s+i]), 32'd1);
    chk("t1_stall_done", 32'(h_stall[s+4]), 32'd0);

    // Data write 0x0100 <- 0x12345678
    do_reset();
    s = cyc;
    i_d_req = 1'b1; i_d_rw = 1'b1; i_d_addr = 16'h0100; i_d_wdata = 32'h12345678;
    repeat (4) step();
    chk("t2_valid", 32'(h_valid[s+1]), 32'd1);
    chk("t2_rw", 32'(h_rw[s+1]), 32'd1);
    chk("t2_addr", 32'(h_addr[s+1]), 32'h0100);
    chk("t2_wdata", h_wdata[s+1], 32'h12345678);
    chk("t2_d_ready", 32'(h_d_rdy[s+2]), 32'd1);
    for (int i = 0; i < 4; i++) chk("t2_if_ready", 32'(h_if_rdy[s+i]), 32'd0);

    // Both requests held continuously: D,D,D,I,D,D,D,I
    do_reset();
    cont_pct = 100;
    i_if_req = 1'b1; new_if_fields();
    i_d_req = 1'b1; new_d_fields();
    pulses = 0; order = '0; guard = 0;
    while (pulses < 8 && guard < 200) begin
      step();
      guard++;
      if (prev_d_ready)  begin order = {order[6:0], 1'b1}; pulses++; end
      if (prev_if_ready) begin order = {order[6:0], 1'b0}; pulses++; end
    end
    chk("t3_pulses", 32'(pulses), 32'd8);
    chk("t3_order", 32'(order), 32'h000000EE);
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("t3_stat_grants", 32'(o_stat_grants), 32'd8);
    chk("t3_stat_conflicts", 32'(o_stat_conflicts), 32'd8);
`endif

    // Fetch raised during WAIT of a data read
    do_reset();
    s = cyc;
    i_d_req = 1'b1; i_d_rw = 1'b0; i_d_addr = 16'h0040; i_d_wdata = 32'h0;
    step(); step();
    i_if_req = 1'b1; i_if_addr = 16'h0080;
    repeat (9) step();
    chk("t4_d_ready", 32'(h_d_rdy[s+4]), 32'd1);
    for (int i = 2; i < 6; i++) chk("t4_no_strobe", 32'(h_valid[s+i]), 32'd0);
    chk("t4_if_valid", 32'(h_valid[s+6]), 32'd1);
    chk("t4_if_addr", 32'(h_addr[s+6]), 32'h0080);
    chk("t4_if_ready", 32'(h_if_rdy[s+9]), 32'd1);

    // Reset during WAIT of a fetch read
    do_reset();
    s = cyc;
    i_if_req = 1'b1; i_if_addr = 16'h0200;
    step(); step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 4; i++) chk("t5_no_ready", 32'(h_if_rdy[s+i]), 32'd0);
    chk("t5_valid0", 32'(h_valid[s+3]), 32'd0);
    chk("t5_addr0", 32'(h_addr[s+3]), 32'd0);
    chk("t5_d_ready0", 32'(h_d_rdy[s+3]), 32'd0);
    chk("t5_if_data0", h_if_data[s+3], 32'd0);
    chk("t5_refetch_ready", 32'(h_if_rdy[s+7]), 32'd1);
    chk("t5_refetch_data", h_if_data[s+7], seed_word(16'h0200));

    // Randomized traffic with occasional resets
    do_reset();
    raise_pct = 30; cont_pct = 50; force_rw = -1;
    repeat (3000) begin
      i_reset = ($urandom_range(0, 499) == 0);
      step();
      i_reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
